// File: rtl/rvvi_trace_pkg.sv
// rvvi_trace_pkg: shared widths, record layout and states for the RVVI trace producer (CSR fields under RVVI_TRACE_CSR_EN).
package rvvi_trace_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int ORDER_W = 64;

    localparam logic [1:0] MODE_U = 2'd0;
    localparam logic [1:0] MODE_S = 2'd1;
    localparam logic [1:0] MODE_M = 2'd3;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} tx_state_e;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [XLEN-1:0]    pc;
        logic [ILEN-1:0]    insn;
        logic               trap;
        logic [1:0]         mode;
        logic               x_wb;
        logic [4:0]         addr;
        logic [XLEN-1:0]    data;
`ifdef RVVI_TRACE_CSR_EN
        logic               csr_wb;
        logic [11:0]        csr_addr;
        logic [XLEN-1:0]    csr_data;
`endif
    } rvvi_rec_t;

endpackage

// File: rtl/rvvi_trace_fifo.sv
// rvvi_trace_fifo: synchronous FIFO of trace records; push ignored when full, pop ignored when empty.
module rvvi_trace_fifo
    import rvvi_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  rvvi_rec_t                wdata,
    output rvvi_rec_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    rvvi_rec_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;
    logic              push_ok, pop_ok;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_ok);
            rd_q  <= rd_q + AW'(pop_ok);
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/rvvi_trace_tx.sv
// rvvi_trace_tx: stamps core retirements with order numbers, buffers and streams them with halt/drain and drop accounting.
// Optional CSR writeback fields are enabled by defining RVVI_TRACE_CSR_EN.
module rvvi_trace_tx
    import rvvi_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               retire_valid,
    output logic               retire_ready,
    input  logic [XLEN-1:0]    retire_pc,
    input  logic [ILEN-1:0]    retire_insn,
    input  logic               retire_trap,
    input  logic [1:0]         retire_mode,
    input  logic               retire_rd_wen,
    input  logic [4:0]         retire_rd_addr,
    input  logic [XLEN-1:0]    retire_rd_data,
`ifdef RVVI_TRACE_CSR_EN
    input  logic               retire_csr_wen,
    input  logic [11:0]        retire_csr_addr,
    input  logic [XLEN-1:0]    retire_csr_data,
    output logic               tr_csr_wb,
    output logic [11:0]        tr_csr_addr,
    output logic [XLEN-1:0]    tr_csr_data,
`endif
    output logic               tr_valid,
    input  logic               tr_ready,
    output logic [ORDER_W-1:0] tr_order,
    output logic [XLEN-1:0]    tr_pc,
    output logic [ILEN-1:0]    tr_insn,
    output logic               tr_trap,
    output logic [1:0]         tr_mode,
    output logic               tr_x_wb,
    output logic [4:0]         tr_x_wb_addr,
    output logic [XLEN-1:0]    tr_x_wb_data,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt,
    input  logic               clr_ovf
);

    tx_state_e                 state_q, state_d;
    logic [ORDER_W-1:0]        order_q, order_d;
    logic                      ovf_q, ovf_d;
    logic [DROP_W-1:0]         drop_q, drop_d;
    logic                      full, empty, push, pop, drop;
    logic [$clog2(DEPTH):0]    count;
    rvvi_rec_t                 wrec, hrec, orec;

    assign retire_ready = !full && state_q == RUN;
    assign push         = retire_valid && retire_ready;
    assign drop         = retire_valid && !retire_ready;
    assign pop          = !empty && tr_ready;

    always_comb begin
        wrec       = '0;
        wrec.order = order_q;
        wrec.pc    = retire_pc;
        wrec.insn  = retire_insn;
        wrec.trap  = retire_trap;
        wrec.mode  = retire_mode;
        wrec.x_wb  = retire_rd_wen && !retire_trap && retire_rd_addr != 5'd0;
        wrec.addr  = wrec.x_wb ? retire_rd_addr : 5'd0;
        wrec.data  = wrec.x_wb ? retire_rd_data : '0;
`ifdef RVVI_TRACE_CSR_EN
        wrec.csr_wb   = retire_csr_wen && !retire_trap;
        wrec.csr_addr = wrec.csr_wb ? retire_csr_addr : 12'd0;
        wrec.csr_data = wrec.csr_wb ? retire_csr_data : '0;
`endif
    end

    rvvi_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wrec),
        .rdata (hrec),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Blank the fields when empty so idle/reset outputs read as zero
    assign orec         = empty ? '0 : hrec;
    assign tr_valid     = !empty;
    assign tr_order     = orec.order;
    assign tr_pc        = orec.pc;
    assign tr_insn      = orec.insn;
    assign tr_trap      = orec.trap;
    assign tr_mode      = orec.mode;
    assign tr_x_wb      = orec.x_wb;
    assign tr_x_wb_addr = orec.addr;
    assign tr_x_wb_data = orec.data;
`ifdef RVVI_TRACE_CSR_EN
    assign tr_csr_wb    = orec.csr_wb;
    assign tr_csr_addr  = orec.csr_addr;
    assign tr_csr_data  = orec.csr_data;
`endif

    assign halted   = state_q == HALTED;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;

    always_comb begin
        state_d = (state_q == RUN    && halt_req)     ? DRAIN  :
                  (state_q == DRAIN  && count == '0)  ? HALTED :
                  (state_q == HALTED && resume)       ? RUN    : state_q;
        order_d = order_q + ORDER_W'(push);
        ovf_d   = drop || (ovf_q && !clr_ovf);
        drop_d  = clr_ovf ? DROP_W'(drop) : drop_q + DROP_W'(drop && !(&drop_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            order_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_rvvi_trace_tx.sv
// tb_rvvi_trace_tx: table vectors, directed corner sequences and a queue-based random reference model for rvvi_trace_tx.
module tb_rvvi_trace_tx;
    import rvvi_trace_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic retire_valid, retire_ready, retire_trap, retire_rd_wen;
    logic [31:0] retire_pc, retire_insn, retire_rd_data;
    logic [1:0] retire_mode;
    logic [4:0] retire_rd_addr;
    logic tr_valid, tr_ready, tr_trap, tr_x_wb;
    logic [63:0] tr_order;
    logic [31:0] tr_pc, tr_insn, tr_x_wb_data;
    logic [1:0] tr_mode;
    logic [4:0] tr_x_wb_addr;
    logic halt_req, resume, halted, overflow, clr_ovf;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    rvvi_trace_tx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .retire_pc(retire_pc), .retire_insn(retire_insn), .retire_trap(retire_trap),
        .retire_mode(retire_mode), .retire_rd_wen(retire_rd_wen),
        .retire_rd_addr(retire_rd_addr), .retire_rd_data(retire_rd_data),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_order(tr_order),
        .tr_pc(tr_pc), .tr_insn(tr_insn), .tr_trap(tr_trap), .tr_mode(tr_mode),
        .tr_x_wb(tr_x_wb), .tr_x_wb_addr(tr_x_wb_addr), .tr_x_wb_data(tr_x_wb_data),
        .halt_req(halt_req), .resume(resume), .halted(halted),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        retire_valid = 1'b0;
        halt_req = 1'b0;
        resume = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic rt(input logic [31:0] pc);
        retire_valid = 1'b1;
        retire_pc = pc;
        retire_insn = pc ^ 32'h13;
        retire_trap = 1'b0;
        retire_mode = MODE_M;
        retire_rd_wen = 1'b1;
        retire_rd_addr = 5'd1;
        retire_rd_data = pc;
    endtask

    typedef struct {
        logic trap; logic [1:0] mode; logic wen; logic [4:0] a; logic [31:0] d;
        logic xwb; logic [4:0] xa; logic [31:0] xd;
    } vec_t;
    vec_t vt[5];

    typedef struct {
        logic [63:0] order; logic [31:0] pc, insn; logic trap; logic [1:0] mode;
        logic wb; logic [4:0] a; logic [31:0] d;
    } mrec_t;
    mrec_t mq[$];

    initial begin
        logic [63:0] m_order;
        logic m_ovf;
        logic [15:0] m_drop;
        int m_st;
        vt[0] = '{1'b0, MODE_M, 1'b1, 5'd0,  32'hDEAD,     1'b0, 5'd0,  32'h0};
        vt[1] = '{1'b1, MODE_U, 1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  32'h0};
        vt[2] = '{1'b0, MODE_S, 1'b1, 5'd5,  32'h1234,     1'b1, 5'd5,  32'h1234};
        vt[3] = '{1'b0, MODE_M, 1'b0, 5'd7,  32'h55,       1'b0, 5'd0,  32'h0};
        vt[4] = '{1'b0, MODE_U, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
        idle();
        tr_ready = 1'b0;
        rt(32'h0);
        retire_valid = 1'b0;
        tick();
        chk("rst_ready", retire_ready, 1);
        chk("rst_valid", tr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_order", tr_order, 0);
        chk("rst_pc", tr_pc, 0);
        rst_n = 1'b1;
        tick();

        // back-to-back retires, 1-cycle latency
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rt(32'h100 + 32'(4 * i));
            tick();
            chk("b2b_valid", tr_valid, 1);
            chk("b2b_order", tr_order, 64'(i));
            chk("b2b_pc", tr_pc, 64'(32'h100 + 32'(4 * i)));
        end
        idle();
        tick();
        chk("b2b_empty", tr_valid, 0);

        // writeback field gating table
        for (int i = 0; i < 5; i++) begin
            tr_ready = 1'b0;
            rt(32'h180 + 32'(4 * i));
            retire_trap = vt[i].trap;
            retire_mode = vt[i].mode;
            retire_rd_wen = vt[i].wen;
            retire_rd_addr = vt[i].a;
            retire_rd_data = vt[i].d;
            tick();
            idle();
            chk("tab_valid", tr_valid, 1);
            chk("tab_order", tr_order, 64'(3 + i));
            chk("tab_trap", tr_trap, vt[i].trap);
            chk("tab_mode", tr_mode, vt[i].mode);
            chk("tab_xwb", tr_x_wb, vt[i].xwb);
            chk("tab_addr", tr_x_wb_addr, vt[i].xa);
            chk("tab_data", tr_x_wb_data, vt[i].xd);
            tr_ready = 1'b1;
            tick();
            chk("tab_pop", tr_valid, 0);
        end

        // fill to full with stalled consumer, two drops
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("full_ready", retire_ready, k < 8 ? 1 : 0);
            rt(32'h200 + 32'(4 * k));
            tick();
        end
        idle();
        chk("full_ovf", overflow, 1);
        chk("full_drop", drop_cnt, 2);
        tr_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("full_valid", tr_valid, 1);
            chk("full_order", tr_order, 64'(j));
            chk("full_pc", tr_pc, 64'(32'h200 + 32'(4 * j)));
            tick();
        end
        chk("full_drained", tr_valid, 0);
        rt(32'h300);
        tick();
        idle();
        chk("after_drop_order", tr_order, 8);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);

        // halt with 5 queued entries
        tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rt(32'h400 + 32'(4 * i));
            tick();
        end
        idle();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("drain_ready", retire_ready, 0);
        chk("drain_halted", halted, 0);
        tr_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("drain_valid", tr_valid, 1);
            chk("drain_order", tr_order, 64'(9 + j));
            chk("drain_nothalt", halted, 0);
            tick();
        end
        chk("drain_empty_valid", tr_valid, 0);
        chk("drain_empty_halted", halted, 0);
        tick();
        chk("halted", halted, 1);
        chk("halted_ready", retire_ready, 0);
        retire_valid = 1'b1;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_vs_drop_ovf", overflow, 1);
        chk("clr_vs_drop_cnt", drop_cnt, 1);
        tick();
        retire_valid = 1'b0;
        chk("halted_drop_cnt", drop_cnt, 2);
        force dut.drop_q = 16'hFFFF;
        tick();
        release dut.drop_q;
        retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        chk("drop_saturate", drop_cnt, 16'hFFFF);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_in_halted", halted, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_ready", retire_ready, 1);
        rt(32'h500);
        tick();
        idle();
        chk("resume_order", tr_order, 14);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("empty_halt_1", halted, 0);
        tick();
        chk("empty_halt_2", halted, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;

        // order wrap
        tr_ready = 1'b0;
        force dut.order_q = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.order_q;
        rt(32'h600);
        tick();
        rt(32'h604);
        tick();
        idle();
        chk("wrap_max", tr_order, 64'hFFFF_FFFF_FFFF_FFFF);
        tr_ready = 1'b1;
        tick();
        chk("wrap_zero", tr_order, 0);
        chk("wrap_pc", tr_pc, 32'h604);
        tick();

        // asynchronous reset mid-operation
        tr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rt(32'h680 + 32'(4 * i));
            tick();
        end
        idle();
        chk("pre_rst_valid", tr_valid, 1);
        chk("pre_rst_ovf", overflow, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", tr_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_ready", retire_ready, 1);
        #1 rst_n = 1'b1;
        tick();
        rt(32'h700);
        tick();
        idle();
        chk("arst_order", tr_order, 0);
        chk("arst_pc", tr_pc, 32'h700);
        tr_ready = 1'b1;
        tick();

        // random traffic against a queue model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m_order = '0; m_ovf = 1'b0; m_drop = '0; m_st = 0;
        mq.delete();
        for (int c = 0; c < 1500; c++) begin
            logic exp_rdy, acc, drp, was_empty;
            mrec_t r;
            exp_rdy = mq.size() < DEPTH && m_st == 0;
            chk("rnd_ready", retire_ready, exp_rdy);
            chk("rnd_valid", tr_valid, mq.size() > 0);
            chk("rnd_halted", halted, m_st == 2);
            chk("rnd_ovf", overflow, m_ovf);
            chk("rnd_drop", drop_cnt, m_drop);
            if (mq.size() > 0) begin
                chk("rnd_order", tr_order, mq[0].order);
                chk("rnd_pc", tr_pc, mq[0].pc);
                chk("rnd_insn", tr_insn, mq[0].insn);
                chk("rnd_trap", tr_trap, mq[0].trap);
                chk("rnd_mode", tr_mode, mq[0].mode);
                chk("rnd_xwb", tr_x_wb, mq[0].wb);
                chk("rnd_addr", tr_x_wb_addr, mq[0].a);
                chk("rnd_data", tr_x_wb_data, mq[0].d);
            end
            retire_valid = $urandom_range(0, 9) < 6;
            retire_pc = $urandom;
            retire_insn = $urandom;
            retire_trap = $urandom_range(0, 5) == 0;
            retire_mode = 2'($urandom_range(0, 3));
            retire_rd_wen = $urandom_range(0, 3) != 0;
            retire_rd_addr = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            retire_rd_data = $urandom;
            tr_ready = $urandom_range(0, 3) != 0;
            clr_ovf = $urandom_range(0, 24) == 0;
            halt_req = $urandom_range(0, 79) == 0;
            resume = $urandom_range(0, 9) == 0;
            acc = retire_valid && exp_rdy;
            drp = retire_valid && !exp_rdy;
            was_empty = mq.size() == 0;
            if (!was_empty && tr_ready) void'(mq.pop_front());
            if (acc) begin
                r.order = m_order;
                r.pc = retire_pc;
                r.insn = retire_insn;
                r.trap = retire_trap;
                r.mode = retire_mode;
                r.wb = retire_rd_wen && !retire_trap && retire_rd_addr != 0;
                r.a = r.wb ? retire_rd_addr : 5'd0;
                r.d = r.wb ? retire_rd_data : 32'd0;
                mq.push_back(r);
                m_order = m_order + 1;
            end
            if (clr_ovf) begin
                m_ovf = drp;
                m_drop = drp ? 16'd1 : 16'd0;
            end else if (drp) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
            end
            if (m_st == 0 && halt_req) m_st = 1;
            else if (m_st == 1 && was_empty) m_st = 2;
            else if (m_st == 2 && resume) m_st = 0;
            tick();
        end
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
